// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdId,
        StRdTs,
        StCheck,
        StGap,
        StDone
    } state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef struct packed {
        logic pass;
        logic id_mismatch;
        logic ts_mismatch;
        logic timeout;
    } status_t;

endpackage

// File: rtl/sysid_wait_timer.sv
// Loadable down-counter with a terminal flag; counts GAP idle cycles or
// waitrequest stall cycles depending on what the owner loads into it.
module sysid_wait_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             dec_i,
    output logic             terminal_o
);

    logic [WIDTH-1:0] count_q;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign terminal_o = (count_q == '0);

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads the system-ID and timestamp words, compares them
// against build-time constants and publishes sticky pass/fail status.
module sysid_boot_checker
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1403181268,
    parameter int unsigned MAX_RETRIES        = 2,
    parameter int unsigned RETRY_GAP          = 8,
    parameter int unsigned TIMEOUT_CYCLES     = 64,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  attempts
);

    localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > RETRY_GAP) ? TIMEOUT_CYCLES : RETRY_GAP;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(RETRY_GAP - 1);

    state_e               state_q, state_d;
    status_t              status_q;
    // One bit wider than the port so MAX_RETRIES=15 still terminates.
    logic [4:0]           attempts_q;
    logic [31:0]          id_value_q, ts_value_q;

    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_load_value;
    logic                 timer_dec;
    logic                 timer_done;
    logic                 in_read;
    logic                 retry_ok;
    logic                 words_match;

    assign in_read     = (state_q == StRdId) || (state_q == StRdTs);
    assign retry_ok    = (32'(attempts_q) <= MAX_RETRIES);
    assign words_match = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TIMESTAMP);

    // Timer reloads on every state change; counts stalls in reads, every cycle in GAP.
    assign timer_load       = (state_d != state_q);
    assign timer_load_value = (state_d == StGap) ? GAP_LOAD : TIMEOUT_LOAD;
    assign timer_dec        = (in_read && avm_waitrequest) || (state_q == StGap);

    sysid_wait_timer #(
        .WIDTH (TIMER_W)
    ) u_wait_timer (
        .clk_i        (clock),
        .rst_i        (reset),
        .load_i       (timer_load),
        .load_value_i (timer_load_value),
        .dec_i        (timer_dec),
        .terminal_o   (timer_done)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a timed-out read jumps straight to the retry decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (AUTO_START || start) state_d = StRdId;
            end
            StRdId: begin
                if (!avm_waitrequest)  state_d = StRdTs;
                else if (timer_done)   state_d = retry_ok ? StGap : StDone;
            end
            StRdTs: begin
                if (!avm_waitrequest)  state_d = StCheck;
                else if (timer_done)   state_d = retry_ok ? StGap : StDone;
            end
            StCheck: begin
                if (words_match)       state_d = StDone;
                else if (retry_ok)     state_d = StGap;
                else                   state_d = StDone;
            end
            StGap: begin
                if (timer_done) state_d = StRdId;
            end
            StDone: begin
                if (start) state_d = StRdId;
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        avm_read    = 1'b0;
        avm_address = ADDR_ID;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            StIdle: busy = 1'b0;
            StRdId: avm_read = 1'b1;
            StRdTs: begin
                avm_read    = 1'b1;
                avm_address = ADDR_TS;
            end
            StDone: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture registers, status flags and attempt counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q   <= '0;
            attempts_q <= '0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (state_d == StRdId) begin
                        status_q   <= '0;
                        attempts_q <= 5'd1;
                    end
                end
                StRdId: begin
                    if (!avm_waitrequest)  id_value_q       <= avm_readdata;
                    else if (timer_done)   status_q.timeout <= 1'b1;
                end
                StRdTs: begin
                    if (!avm_waitrequest)  ts_value_q       <= avm_readdata;
                    else if (timer_done)   status_q.timeout <= 1'b1;
                end
                StCheck: begin
                    status_q.id_mismatch <= (id_value_q != EXPECTED_ID);
                    status_q.ts_mismatch <= (ts_value_q != EXPECTED_TIMESTAMP);
                    status_q.pass        <= words_match;
                end
                StGap: begin
                    if (timer_done) begin
                        status_q   <= '0;
                        attempts_q <= attempts_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass        = status_q.pass;
    assign id_mismatch = status_q.id_mismatch;
    assign ts_mismatch = status_q.ts_mismatch;
    assign timeout     = status_q.timeout;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign attempts    = (attempts_q > 5'd15) ? 4'd15 : attempts_q[3:0];

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Self-checking bench: randomized Avalon slave plus an attempt-level reference model.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'h0;
    localparam logic [31:0] EXP_TS = 32'd1403181268;
    localparam int MAXR = 2;
    localparam int GAP  = 8;
    localparam int TMO  = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] id_value, ts_value;
    logic [3:0]  attempts;

    int total = 0;
    int bad = 0;

    // Read plan: one entry per read episode, consumed in order by slave and model.
    int          plan_stall [16];
    logic [31:0] plan_data  [16];
    int          plan_gen = 0;

    // Slave-side bookkeeping (written only by the slave process).
    int   seen_gen = 0;
    int   idx = 0;
    int   stall_left = 0;
    bit   active = 0;
    bit   ep_addr = 0;
    bit   next_is_ts = 0;
    int   addr_viol = 0;
    int   quiet_cnt = 0;

    // Reference model results.
    int          m_edges, m_quiet, m_att;
    bit          m_pass, m_idm, m_tsm, m_to;
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    sysid_boot_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .MAX_RETRIES        (MAXR),
        .RETRY_GAP          (GAP),
        .TIMEOUT_CYCLES     (TMO),
        .AUTO_START         (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_mismatch     (id_mismatch),
        .ts_mismatch     (ts_mismatch),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .attempts        (attempts)
    );

    always #5 clock = ~clock;

    // Slave: drives waitrequest/readdata on the falling edge from the plan.
    always @(negedge clock) begin
        if (plan_gen != seen_gen) begin
            seen_gen   = plan_gen;
            idx        = 0;
            active     = 0;
            next_is_ts = 0;
            addr_viol  = 0;
            quiet_cnt  = 0;
        end
        if (reset) begin
            active          = 0;
            next_is_ts      = 0;
            avm_waitrequest = 1'b0;
        end else begin
            if (active) begin
                if (!avm_waitrequest) begin
                    // accepted at the last rising edge; a TS read may follow an ID read only
                    active     = 0;
                    next_is_ts = !ep_addr;
                    idx++;
                end else if (!avm_read) begin
                    active     = 0;
                    next_is_ts = 0;
                    idx++;
                end else if (avm_address != ep_addr) begin
                    addr_viol++;
                end
            end
            if (!active && avm_read) begin
                active     = 1;
                ep_addr    = avm_address;
                if (avm_address != next_is_ts) addr_viol++;
                stall_left = plan_stall[idx];
            end
            if (active) begin
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = plan_data[idx];
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata    = $urandom;
            end
            if (!avm_read && busy) quiet_cnt++;
        end
    end

    // Attempt-level model: edges from the launching edge until done, plus final status.
    task automatic model_run();
        int  k = 0;
        int  att = 0;
        bit  fin = 0;
        m_edges = 1;
        m_quiet = 0;
        m_pass  = 0;
        while (!fin) begin
            att++;
            m_to = 0; m_idm = 0; m_tsm = 0;
            if (plan_stall[k] >= TMO) begin
                m_edges += TMO; k++; m_to = 1;
            end else begin
                m_edges += plan_stall[k] + 1; m_id = plan_data[k]; k++;
                if (plan_stall[k] >= TMO) begin
                    m_edges += TMO; k++; m_to = 1;
                end else begin
                    m_edges += plan_stall[k] + 1; m_ts = plan_data[k]; k++;
                    m_edges += 1; m_quiet += 1;
                    m_idm  = (m_id != EXP_ID);
                    m_tsm  = (m_ts != EXP_TS);
                    m_pass = !m_idm && !m_tsm;
                end
            end
            if (m_pass || att > MAXR) fin = 1;
            else begin
                m_edges += GAP; m_quiet += GAP;
            end
        end
        m_att = att;
    endtask

    task automatic fill_plan(input int stall, input logic [31:0] id, input logic [31:0] ts);
        for (int i = 0; i < 16; i++) begin
            plan_stall[i] = stall;
            plan_data[i]  = (i % 2 == 0) ? id : ts;
        end
    endtask

    // Triggers a run (start pulse or reset release) and counts edges until done.
    task automatic launch(input bit use_start, input int pulse_at, output int edges);
        bit seen = 0;
        plan_gen++;
        @(negedge clock);
        if (use_start) start = 1'b1;
        else           reset = 1'b0;
        edges = 0;
        while (!seen && edges < 3000) begin
            @(posedge clock);
            edges++;
            #1;
            start = (edges == pulse_at);
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) edges = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total++;
        if ({avm_read, avm_address, busy, done} !== 4'b0) begin
            bad++; $display("FAIL rst_ctrl: got %b want 0000", {avm_read, avm_address, busy, done});
        end
        total++;
        if ({pass, id_mismatch, ts_mismatch, timeout} !== 4'b0) begin
            bad++; $display("FAIL rst_status: got %b want 0000",
                            {pass, id_mismatch, ts_mismatch, timeout});
        end
        total++;
        if ({id_value, ts_value, attempts} !== 68'b0) begin
            bad++; $display("FAIL rst_values: id %h ts %h att %0d want 0", id_value, ts_value,
                            attempts);
        end
    endtask

    task automatic test_zero_wait();
        int n;
        fill_plan(0, EXP_ID, EXP_TS);
        model_run();
        launch(1'b0, 0, n);
        total++;
        if (n !== m_edges) begin bad++; $display("FAIL zw_latency: got %0d want %0d", n, m_edges); end
        total++;
        if (pass !== 1'b1) begin bad++; $display("FAIL zw_pass: got %b want 1", pass); end
        total++;
        if (attempts !== 4'(m_att)) begin
            bad++; $display("FAIL zw_attempts: got %0d want %0d", attempts, m_att);
        end
        total++;
        if (id_value !== m_id || ts_value !== m_ts) begin
            bad++; $display("FAIL zw_values: got %h/%0d want %h/%0d", id_value, ts_value, m_id, m_ts);
        end
    endtask

    task automatic test_stall();
        int n;
        fill_plan(3, EXP_ID, EXP_TS);
        model_run();
        launch(1'b1, 0, n);
        total++;
        if (n !== m_edges) begin bad++; $display("FAIL st_latency: got %0d want %0d", n, m_edges); end
        total++;
        if (pass !== 1'b1) begin bad++; $display("FAIL st_pass: got %b want 1", pass); end
        total++;
        if (addr_viol !== 0) begin bad++; $display("FAIL st_addr: got %0d violations want 0", addr_viol); end
        total++;
        if (quiet_cnt !== m_quiet) begin
            bad++; $display("FAIL st_quiet: got %0d want %0d", quiet_cnt, m_quiet);
        end
    endtask

    task automatic test_retry_id();
        int n;
        fill_plan(0, EXP_ID, EXP_TS);
        plan_data[0] = 32'h1;
        model_run();
        launch(1'b1, 0, n);
        total++;
        if (n !== m_edges) begin bad++; $display("FAIL rt_latency: got %0d want %0d", n, m_edges); end
        total++;
        if (quiet_cnt !== m_quiet) begin
            bad++; $display("FAIL rt_gap: got %0d quiet cycles want %0d", quiet_cnt, m_quiet);
        end
        total++;
        if ({pass, id_mismatch, attempts} !== {m_pass, m_idm, 4'(m_att)}) begin
            bad++; $display("FAIL rt_status: got p%b idm%b att%0d want p%b idm%b att%0d",
                            pass, id_mismatch, attempts, m_pass, m_idm, m_att);
        end
    endtask

    task automatic test_ts_fail();
        int n;
        fill_plan(0, EXP_ID, EXP_TS - 32'd1);
        model_run();
        launch(1'b1, 0, n);
        total++;
        if (n !== m_edges) begin bad++; $display("FAIL tf_latency: got %0d want %0d", n, m_edges); end
        total++;
        if ({done, pass, ts_mismatch, id_mismatch} !== {1'b1, m_pass, m_tsm, m_idm}) begin
            bad++; $display("FAIL tf_status: got %b want %b", {done, pass, ts_mismatch, id_mismatch},
                            {1'b1, m_pass, m_tsm, m_idm});
        end
        total++;
        if (attempts !== 4'(m_att)) begin
            bad++; $display("FAIL tf_attempts: got %0d want %0d", attempts, m_att);
        end
    endtask

    task automatic test_timeout();
        int n;
        fill_plan(1000, EXP_ID, EXP_TS);
        model_run();
        launch(1'b1, 0, n);
        total++;
        if (n !== m_edges) begin bad++; $display("FAIL to_latency: got %0d want %0d", n, m_edges); end
        total++;
        if ({timeout, pass, done} !== {m_to, m_pass, 1'b1}) begin
            bad++; $display("FAIL to_status: got %b want %b", {timeout, pass, done},
                            {m_to, m_pass, 1'b1});
        end
        total++;
        if (attempts !== 4'(m_att)) begin
            bad++; $display("FAIL to_attempts: got %0d want %0d", attempts, m_att);
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 16; i++) begin
                plan_stall[i] = ($urandom_range(0, 9) == 0) ? TMO + int'($urandom_range(0, 5))
                                                           : int'($urandom_range(0, 4));
                if ($urandom_range(0, 3) == 0) plan_data[i] = $urandom;
                else                           plan_data[i] = (i % 2 == 0) ? EXP_ID : EXP_TS;
            end
            model_run();
            launch(1'b1, 0, n);
            total++;
            if (n !== m_edges) begin
                bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", r, n, m_edges);
            end
            total++;
            if ({pass, id_mismatch, ts_mismatch, timeout} !== {m_pass, m_idm, m_tsm, m_to}) begin
                bad++; $display("FAIL rnd%0d_status: got %b want %b", r,
                                {pass, id_mismatch, ts_mismatch, timeout}, {m_pass, m_idm, m_tsm, m_to});
            end
            total++;
            if (attempts !== 4'(m_att) || id_value !== m_id || ts_value !== m_ts) begin
                bad++; $display("FAIL rnd%0d_values: got att%0d %h %h want att%0d %h %h", r,
                                attempts, id_value, ts_value, m_att, m_id, m_ts);
            end
            total++;
            if (addr_viol !== 0 || quiet_cnt !== m_quiet) begin
                bad++; $display("FAIL rnd%0d_bus: got viol%0d quiet%0d want viol0 quiet%0d", r,
                                addr_viol, quiet_cnt, m_quiet);
            end
        end
    endtask

    task automatic test_busy_start();
        int n;
        fill_plan(3, EXP_ID, EXP_TS);
        model_run();
        launch(1'b1, 6, n);
        total++;
        if (n !== m_edges) begin bad++; $display("FAIL bs_latency: got %0d want %0d", n, m_edges); end
        total++;
        if ({pass, attempts} !== {1'b1, 4'(m_att)}) begin
            bad++; $display("FAIL bs_status: got p%b att%0d want p1 att%0d", pass, attempts, m_att);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit hit = 0;
        for (int i = 0; i < 16; i++) begin
            plan_stall[i] = 10;
            plan_data[i]  = 32'hA5A5_0000 | 32'(i + 1);
        end
        plan_gen++;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        while (!hit && n < 200) begin
            @(posedge clock);
            n++;
            #1;
            if (avm_read && avm_address) hit = 1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rm_reach: got no RD_TS want RD_TS within 200"); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({avm_read, busy, done, pass, id_mismatch, ts_mismatch, timeout} !== 7'b0) begin
            bad++; $display("FAIL rm_async: got %b want 0000000",
                            {avm_read, busy, done, pass, id_mismatch, ts_mismatch, timeout});
        end
        total++;
        if ({id_value, attempts} !== 36'b0) begin
            bad++; $display("FAIL rm_values: got id %h att %0d want 0", id_value, attempts);
        end
        m_id = '0;
        m_ts = '0;
        repeat (2) @(negedge clock);
        fill_plan(0, EXP_ID, EXP_TS);
        model_run();
        launch(1'b0, 0, n);
        total++;
        if (n !== m_edges || pass !== 1'b1) begin
            bad++; $display("FAIL rm_rerun: got edges%0d p%b want edges%0d p1", n, pass, m_edges);
        end
        total++;
        if (id_value !== m_id || ts_value !== m_ts || attempts !== 4'(m_att)) begin
            bad++; $display("FAIL rm_capture: got %h %0d att%0d want %h %0d att%0d",
                            id_value, ts_value, attempts, m_id, m_ts, m_att);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_retry_id();
        test_ts_fail();
        test_timeout();
        test_random();
        test_busy_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM master that sits directly downstream of the system-ID slave.
- After reset, or on request, it reads the ID word (address 0) and the build timestamp word (address 1), then compares both against build-time constants.
- Publishes sticky pass/fail status and the captured values. Software or the LT24 bring-up logic gates start-up on a hardware/software build match.
- Bounded retries and a waitrequest timeout guarantee that `done` always asserts.

Parameters:
- EXPECTED_ID, 32'h0: required value at address 0.
- EXPECTED_TIMESTAMP, 32'd1403181268: required value at address 1.
- MAX_RETRIES, 2: extra attempts after a failed attempt (0..15).
- RETRY_GAP, 8: idle cycles between attempts (>=1).
- TIMEOUT_CYCLES, 64: consecutive waitrequest-high cycles that abort an attempt (>=2).
- AUTO_START, 1: 1 = start automatically after reset release.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: single-cycle request to rerun the check; honoured only in IDLE or DONE.
- avm_address, out, 1: 0 = ID word, 1 = timestamp word.
- avm_read, out, 1: read strobe.
- avm_waitrequest, in, 1: slave stall.
- avm_readdata, in, 32: zero-latency read data, valid when avm_read=1 and avm_waitrequest=0.
- busy, out, 1: high in any state other than IDLE or DONE.
- done, out, 1: high while in DONE.
- pass, out, 1: both words matched on the last attempt.
- id_mismatch, out, 1: last attempt's ID differed.
- ts_mismatch, out, 1: last attempt's timestamp differed.
- timeout, out, 1: last attempt was aborted by timeout.
- id_value, out, 32: last captured ID.
- ts_value, out, 32: last captured timestamp.
- attempts, out, 4: attempts made in the current run (1..MAX_RETRIES+1).

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs, captured values and counters go to 0; avm_read=0, avm_address=0.
- States: IDLE, RD_ID, RD_TS, CHECK, GAP, DONE. avm_read and avm_address decode from the state register (Moore outputs).
- IDLE:
  - Goes to RD_ID on the first edge with reset low when AUTO_START=1, or on start=1.
  - Entering from IDLE/DONE clears the status flags and sets attempts=1.
- RD_ID:
  - Drives avm_read=1, avm_address=0.
  - On an edge with waitrequest=0: id_value <= readdata, go to RD_TS.
- RD_TS:
  - Drives avm_read=1, avm_address=1.
  - On an edge with waitrequest=0: ts_value <= readdata, go to CHECK.
  - avm_read is held high across the RD_ID to RD_TS boundary; there is no dead cycle.
- Timeout:
  - wait_cnt clears on every state entry and increments in RD_ID/RD_TS while waitrequest=1.
  - When wait_cnt reaches TIMEOUT_CYCLES-1 with waitrequest still 1: timeout <= 1, avm_read drops next cycle, treated as a failed attempt (go straight to the retry decision).
- CHECK (one cycle): id_mismatch <= (id_value != EXPECTED_ID), ts_mismatch <= (ts_value != EXPECTED_TIMESTAMP).
  - Both match: pass <= 1, go to DONE.
  - Otherwise: go to GAP if attempts <= MAX_RETRIES, else go to DONE with pass=0.
- GAP:
  - Holds RETRY_GAP cycles, then increments attempts, clears timeout/mismatch flags, and goes to RD_ID.
- DONE:
  - done=1 and status is held stable until start or reset.
  - start in DONE reruns the check (flags are cleared on the entering edge).
  - start in any busy state is ignored.
- Latency, zero-wait slave:
  - edge1 IDLE→RD_ID, edge2 →RD_TS, edge3 →CHECK, edge4 →DONE.
  - done is high 4 cycles after the first active edge.
  - Each waitrequest cycle adds 1.
- Reset mid-read: avm_read drops asynchronously and no partial status survives. With AUTO_START, the full check restarts after release.
- Values are compared bitwise, unsigned; attempts saturates at 15.

Decomposition:
- Package sysid_check_pkg holds:
  - the state enum;
  - constants ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - the status struct {pass, id_mismatch, ts_mismatch, timeout}.
- Sub-module sysid_wait_timer: a loadable down-counter with a terminal flag, shared by the GAP count and the timeout count.
- The FSM and capture registers stay in the top module.

Test Plan:
- Zero-wait slave returning 0 / 1403181268, AUTO_START=1: done at edge 4, pass=1, attempts=1, id_value=0, ts_value=1403181268.
- waitrequest high for 3 cycles on each read: avm_read is continuous, done at edge 10, pass=1; address is stable while stalled.
- First ID read returns 32'h1, then 0 on the retry: attempt 1 fails, GAP lasts 8 cycles, final state pass=1, attempts=2, id_mismatch=0.
- Timestamp always 1403181267, MAX_RETRIES=2: 3 attempts, done=1, pass=0, ts_mismatch=1, id_mismatch=0, attempts=3.
- waitrequest stuck high, TIMEOUT_CYCLES=64: each attempt aborts after 64 cycles, final state timeout=1, pass=0, attempts=3; done always asserts.
- Reset asserted mid-RD_TS: avm_read=0 and all status 0 immediately. On release, a clean run gives pass=1. start pulsed while busy has no effect.
